// File: rtl/ysyx_23060059_axi_sram.sv
// AXI4 SRAM responder: independent read (INCR bursts) and single-beat write channels.
// Define YSYX_23060059_SRAM_RAND_DELAY_EN for LFSR-driven per-transaction latency (0..7).
module ysyx_23060059_axi_sram #(
    parameter logic [31:0] ADDR_BASE  = 32'h0f000000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        arready,
    output logic        rvalid,
    output logic [1:0]  rresp,
    output logic [63:0] rdata,
    output logic        rlast,
    output logic [3:0]  rid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    output logic        awready,
    input  logic        wvalid,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wlast,
    output logic        wready,
    output logic        bvalid,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    input  logic        bready
);
    localparam int          WORDS    = 1 << DEPTH_LOG2;
    localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + (33'd8 << DEPTH_LOG2);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_e;
    typedef enum logic [2:0] {
        W_IDLE = 3'd0, W_GOTADDR = 3'd1, W_GOTDATA = 3'd2, W_WAIT = 3'd3, W_RESP = 3'd4
    } w_state_e;

    function automatic logic in_range(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, ADDR_BASE}) && ({1'b0, a} < ADDR_END);
    endfunction

    logic [63:0] mem [WORDS];
    logic [3:0]  lat_s;

`ifdef YSYX_23060059_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr_q;
    // Free-running Fibonacci LFSR; its low bits become the next loaded latency
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end
    assign lat_s = {1'b0, lfsr_q[2:0]};
`else
    assign lat_s = 4'(LATENCY);
`endif

    // ---------------- read channel ----------------
    r_state_e    r_state_q, r_state_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [3:0]  r_id_q, r_id_d;
    logic [7:0]  r_len_q, r_len_d;
    logic [7:0]  r_beat_q, r_beat_d;
    logic [1:0]  r_size_q, r_size_d;
    logic [3:0]  r_cnt_q, r_cnt_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [63:0] rdata_q, rdata_d;
    logic [3:0]  rid_q, rid_d;
    logic        r_load_s;
    logic [31:0] r_samp_s;

    // Read FSM next state; a beat's word is fetched on the edge that presents it
    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_id_d    = r_id_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_size_d  = r_size_q;
        r_cnt_d   = r_cnt_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        r_load_s  = 1'b0;
        r_samp_s  = r_addr_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    r_state_d = R_WAIT;
                    r_addr_d  = araddr;
                    r_id_d    = arid;
                    r_len_d   = arlen;
                    r_size_d  = (arsize > 3'd3) ? 2'd3 : arsize[1:0];
                    r_cnt_d   = lat_s;
                    r_beat_d  = 8'd0;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    rlast_d   = (r_len_q == 8'd0);
                    rid_d     = r_id_q;
                    r_load_s  = 1'b1;
                end else begin
                    r_cnt_d = r_cnt_q - 4'd1;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        r_addr_d = r_addr_q + (32'd1 << r_size_q);
                        r_beat_d = r_beat_q + 8'd1;
                        rlast_d  = (r_beat_d == r_len_q);
                        r_samp_s = r_addr_d;
                        r_load_s = 1'b1;
                    end
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
        endcase
        if (r_load_s) begin
            rdata_d = in_range(r_samp_s) ? mem[r_samp_s[DEPTH_LOG2+2:3]] : 64'd0;
            rresp_d = in_range(r_samp_s) ? 2'b00 : 2'b10;
        end else begin
            rdata_d = rdata_q;
            rresp_d = rresp_q;
        end
        arready_d = (r_state_d == R_IDLE);
    end

    // Read-side state and registered R/AR outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= 32'd0;
            r_id_q    <= 4'd0;
            r_len_q   <= 8'd0;
            r_beat_q  <= 8'd0;
            r_size_q  <= 2'd0;
            r_cnt_q   <= 4'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= 64'd0;
            rid_q     <= 4'd0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_id_q    <= r_id_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_size_q  <= r_size_d;
            r_cnt_q   <= r_cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            rid_q     <= rid_d;
        end
    end

    // ---------------- write channel ----------------
    w_state_e    w_state_q, w_state_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [3:0]  w_id_q, w_id_d;
    logic [7:0]  w_len_q, w_len_d;
    logic [63:0] w_data_q, w_data_d;
    logic [7:0]  w_strb_q, w_strb_d;
    logic [3:0]  w_cnt_q, w_cnt_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [3:0]  bid_q, bid_d;
    logic        aw_hs_s, w_hs_s, w_err_s, w_commit_s;

    assign aw_hs_s = awvalid && awready_q;
    assign w_hs_s  = wvalid && wready_q;
    // Bursty writes are refused whole rather than truncated
    assign w_err_s = !in_range(w_addr_q) || (w_len_q != 8'd0);

    // Write FSM next state: AW and W may complete in either order
    always_comb begin
        w_state_d  = w_state_q;
        w_cnt_d    = w_cnt_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        bid_d      = bid_q;
        w_commit_s = 1'b0;
        if (aw_hs_s) begin
            w_addr_d = awaddr;
            w_id_d   = awid;
            w_len_d  = awlen;
        end else begin
            w_addr_d = w_addr_q;
            w_id_d   = w_id_q;
            w_len_d  = w_len_q;
        end
        if (w_hs_s) begin
            w_data_d = wdata;
            w_strb_d = wstrb;
        end else begin
            w_data_d = w_data_q;
            w_strb_d = w_strb_q;
        end
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    w_state_d = W_WAIT;
                    w_cnt_d   = lat_s;
                end else if (aw_hs_s) begin
                    w_state_d = W_GOTADDR;
                end else if (w_hs_s) begin
                    w_state_d = W_GOTDATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_GOTADDR: begin
                if (w_hs_s) begin
                    w_state_d = W_WAIT;
                    w_cnt_d   = lat_s;
                end else begin
                    w_state_d = W_GOTADDR;
                end
            end
            W_GOTDATA: begin
                if (aw_hs_s) begin
                    w_state_d = W_WAIT;
                    w_cnt_d   = lat_s;
                end else begin
                    w_state_d = W_GOTDATA;
                end
            end
            W_WAIT: begin
                if (w_cnt_q == 4'd0) begin
                    w_state_d  = W_RESP;
                    bvalid_d   = 1'b1;
                    bid_d      = w_id_q;
                    bresp_d    = w_err_s ? 2'b10 : 2'b00;
                    w_commit_s = !w_err_s;
                end else begin
                    w_cnt_d = w_cnt_q - 4'd1;
                end
            end
            W_RESP: begin
                if (bvalid_q && bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                bvalid_d  = 1'b0;
            end
        endcase
        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_GOTDATA);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_GOTADDR);
    end

    // Write-side state and registered AW/W/B outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= 32'd0;
            w_id_q    <= 4'd0;
            w_len_q   <= 8'd0;
            w_data_q  <= 64'd0;
            w_strb_q  <= 8'd0;
            w_cnt_q   <= 4'd0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= 4'd0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_id_q    <= w_id_d;
            w_len_q   <= w_len_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            w_cnt_q   <= w_cnt_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
        end
    end

    // Byte-lane commit; memory is deliberately outside the reset domain
    always_ff @(posedge clock) begin
        if (w_commit_s) begin
            for (int i = 0; i < 8; i++) begin
                if (w_strb_q[i]) begin
                    mem[w_addr_q[DEPTH_LOG2+2:3]][i*8 +: 8] <= w_data_q[i*8 +: 8];
                end
            end
        end
    end

    logic unused_s;
    assign unused_s = ^{arburst, awsize, awburst, wlast};

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;
endmodule

// File: tb/tb_ysyx_23060059_axi_sram.sv
// Self-checking bench for ysyx_23060059_axi_sram against a word/byte-level memory model.
module tb_ysyx_23060059_axi_sram;
    localparam logic [31:0]     BASE = 32'h0f000000;
    localparam int              DLOG = 10;
    localparam int              LAT  = 3;
    localparam longint unsigned SPAN = 64'd8 << DLOG;

    logic        clock, reset;
    logic [31:0] araddr, awaddr;
    logic        arvalid, arready, rvalid, rlast, rready;
    logic [3:0]  arid, rid, awid, bid;
    logic [7:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic [63:0] rdata, wdata;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;

    int errors = 0;
    int checks = 0;
    logic [63:0] ref_mem [int unsigned];

    ysyx_23060059_axi_sram #(.ADDR_BASE(BASE), .DEPTH_LOG2(DLOG), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arid(arid), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arready(arready),
        .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awid(awid), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bid(bid), .bready(bready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_in(input logic [31:0] a);
        longint unsigned x, lo;
        x  = a;
        lo = BASE;
        return (x >= lo) && (x < lo + SPAN);
    endfunction

    function automatic int unsigned m_idx(input logic [31:0] a);
        return (a - BASE) >> 3;
    endfunction

    task automatic chk_lat(input string tag, input int cyc);
`ifdef YSYX_23060059_SRAM_RAND_DELAY_EN
        chk(tag, 64'(cyc >= 1 && cyc <= 8), 64'd1);
`else
        chk(tag, 64'(cyc), 64'(1 + LAT));
`endif
    endtask

    // lead > 0: W presented that many cycles before AW; lead < 0: AW first
    task automatic do_write(input string tag, input logic [31:0] a, input logic [63:0] d,
                            input logic [7:0] s, input logic [3:0] id, input logic [7:0] len,
                            input int lead, input int bhold);
        bit aw_done, w_done, half_chk, hs_aw, hs_w;
        int t, cyc, aw_start, w_start;
        logic [1:0]  exp_resp;
        logic [63:0] cur;
        int unsigned idx;
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        awaddr = a; awid = id; awlen = len; awsize = 3'd3; awburst = 2'b01;
        wdata = d; wstrb = s; wlast = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; half_chk = 1'b0; t = 0;
        while (!(aw_done && w_done) && t < 60) begin
            awvalid = !aw_done && (t >= aw_start);
            wvalid  = !w_done && (t >= w_start);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(negedge clock);
            aw_done = aw_done | hs_aw;
            w_done  = w_done | hs_w;
            t++;
            if (w_done && !aw_done && !half_chk) begin
                chk({tag, ".half_awready"}, 64'(awready), 64'd1);
                chk({tag, ".half_wready"}, 64'(wready), 64'd0);
                half_chk = 1'b1;
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk({tag, ".handshake"}, 64'(aw_done && w_done), 64'd1);
        cyc = 0;
        while (!bvalid && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        chk_lat({tag, ".b_latency"}, cyc);
        exp_resp = (m_in(a) && len == 8'd0) ? 2'b00 : 2'b10;
        chk({tag, ".bvalid"}, 64'(bvalid), 64'd1);
        chk({tag, ".bresp"}, 64'(bresp), 64'(exp_resp));
        chk({tag, ".bid"}, 64'(bid), 64'(id));
        bready = 1'b0;
        repeat (bhold) begin
            @(negedge clock);
            chk({tag, ".bvalid_hold"}, 64'(bvalid), 64'd1);
            chk({tag, ".bid_hold"}, 64'(bid), 64'(id));
            chk({tag, ".bresp_hold"}, 64'(bresp), 64'(exp_resp));
        end
        bready = 1'b1;
        @(negedge clock);
        bready = 1'b0;
        chk({tag, ".bvalid_drop"}, 64'(bvalid), 64'd0);
        chk({tag, ".awready_back"}, 64'(awready), 64'd1);
        chk({tag, ".wready_back"}, 64'(wready), 64'd1);
        if (exp_resp == 2'b00) begin
            idx = m_idx(a);
            if (ref_mem.exists(idx)) begin
                cur = ref_mem[idx];
                for (int i = 0; i < 8; i++) begin
                    if (s[i]) cur[i*8 +: 8] = d[i*8 +: 8];
                end
                ref_mem[idx] = cur;
            end else if (s == 8'hFF) begin
                ref_mem[idx] = d;
            end
        end
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [3:0] id,
                           input logic [7:0] len, input logic [2:0] sz, input bit toggle,
                           output logic [63:0] last_d);
        int cyc, step, hold;
        logic [31:0] ba;
        logic [63:0] ed;
        logic [1:0]  er;
        bit known;
        step = 1 << ((sz > 3'd3) ? 3 : int'(sz));
        araddr = a; arid = id; arlen = len; arsize = sz;
        arburst = 2'($urandom_range(0, 3));
        arvalid = 1'b1;
        rready = 1'b0;
        cyc = 0;
        while (!arready && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        @(negedge clock);
        arvalid = 1'b0;
        chk({tag, ".arready_low"}, 64'(arready), 64'd0);
        cyc = 0;
        while (!rvalid && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        chk_lat({tag, ".r_latency"}, cyc);
        last_d = 64'd0;
        for (int b = 0; b <= int'(len); b++) begin
            ba = a + 32'(b * step);
            known = !m_in(ba) || ref_mem.exists(m_idx(ba));
            ed = (m_in(ba) && known) ? ref_mem[m_idx(ba)] : 64'd0;
            er = m_in(ba) ? 2'b00 : 2'b10;
            chk({tag, ".rvalid"}, 64'(rvalid), 64'd1);
            if (known) chk({tag, ".rdata"}, rdata, ed);
            chk({tag, ".rresp"}, 64'(rresp), 64'(er));
            chk({tag, ".rlast"}, 64'(rlast), 64'(b == int'(len)));
            chk({tag, ".rid"}, 64'(rid), 64'(id));
            hold = toggle ? $urandom_range(0, 2) : 0;
            repeat (hold) begin
                @(negedge clock);
                chk({tag, ".rvalid_hold"}, 64'(rvalid), 64'd1);
                if (known) chk({tag, ".rdata_hold"}, rdata, ed);
                chk({tag, ".rlast_hold"}, 64'(rlast), 64'(b == int'(len)));
            end
            last_d = rdata;
            rready = 1'b1;
            @(negedge clock);
            if (toggle) rready = 1'b0;
        end
        rready = 1'b0;
        chk({tag, ".rvalid_end"}, 64'(rvalid), 64'd0);
        chk({tag, ".arready_back"}, 64'(arready), 64'd1);
    endtask

    initial begin
        logic [63:0] got, snap;
        logic [31:0] a;
        logic [7:0]  len;
        logic [2:0]  sz;
        int cyc, step, start;

        reset = 1'b0;
        araddr = 32'd0; arvalid = 1'b0; arid = 4'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0;
        rready = 1'b0; awaddr = 32'd0; awvalid = 1'b0; awid = 4'd0; awlen = 8'd0; awsize = 3'd0;
        awburst = 2'd0; wvalid = 1'b0; wdata = 64'd0; wstrb = 8'd0; wlast = 1'b0; bready = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst.arready", 64'(arready), 64'd0);
        chk("rst.awready", 64'(awready), 64'd0);
        chk("rst.wready", 64'(wready), 64'd0);
        chk("rst.rvalid", 64'(rvalid), 64'd0);
        chk("rst.bvalid", 64'(bvalid), 64'd0);
        chk("rst.rdata", rdata, 64'd0);
        chk("rst.rid_rlast_rresp", {56'd0, rid, rlast, rresp, 1'b0}, 64'd0);
        chk("rst.bid_bresp", {58'd0, bid, bresp}, 64'd0);
        @(negedge clock);
        @(negedge clock);
        chk("rst.arready_held", 64'(arready), 64'd0);
        reset = 1'b0;
        #1;
        chk("rel.arready_before_edge", 64'(arready), 64'd0);
        @(negedge clock);
        chk("rel.arready", 64'(arready), 64'd1);
        chk("rel.awready", 64'(awready), 64'd1);
        chk("rel.wready", 64'(wready), 64'd1);

        for (int w = 0; w < 32; w++) begin
            do_write("init", BASE + 32'(w * 8), {$urandom, $urandom}, 8'hFF, 4'(w),
                     8'd0, $urandom_range(0, 4) - 2, 0);
        end

        do_write("wr_full", 32'h0f000010, 64'h1122334455667788, 8'hFF, 4'h3, 8'd0, 0, 0);
        do_read("rd_full", 32'h0f000010, 4'h9, 8'd0, 3'd3, 1'b0, got);
        chk("rd_full.value", got, 64'h1122334455667788);

        do_write("wr_ff", 32'h0f000020, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 4'h1, 8'd0, 0, 0);
        do_write("wr_byte", 32'h0f000020, 64'h0000AB0000000000, 8'h20, 4'h2, 8'd0, -1, 1);
        do_read("rd_byte", 32'h0f000020, 4'h4, 8'd0, 3'd3, 1'b0, got);
        chk("rd_byte.value", got, 64'hFFFFABFFFFFFFFFF);

        do_write("w_first", 32'h0f000030, 64'hDEADBEEFCAFEF00D, 8'hFF, 4'h7, 8'd0, 5, 3);
        repeat (3) begin
            @(negedge clock);
            chk("w_first.bvalid_once", 64'(bvalid), 64'd0);
        end
        do_read("rd_w_first", 32'h0f000030, 4'h7, 8'd0, 3'd3, 1'b0, got);
        chk("rd_w_first.value", got, 64'hDEADBEEFCAFEF00D);

        do_read("burst4", BASE, 4'hA, 8'd3, 3'd3, 1'b1, got);

        do_read("rd_oor", 32'h0f002000, 4'h2, 8'd0, 3'd3, 1'b0, got);
        chk("rd_oor.value", got, 64'd0);
        do_write("wr_oor", 32'h0f002000, 64'h5555AAAA5555AAAA, 8'hFF, 4'h6, 8'd0, 0, 0);
        do_read("rd_alias", BASE, 4'h1, 8'd0, 3'd3, 1'b0, got);
        do_write("wr_len1", 32'h0f000028, 64'h0123456789ABCDEF, 8'hFF, 4'h8, 8'd1, 0, 0);
        do_read("rd_len1", 32'h0f000028, 4'h1, 8'd0, 3'd3, 1'b0, got);

        // reset while the read waits out its latency
        araddr = 32'h0f000010; arid = 4'h5; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01;
        chk("rstw.arready_pre", 64'(arready), 64'd1);
        arvalid = 1'b1;
        @(negedge clock);
        arvalid = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rstw.rvalid", 64'(rvalid), 64'd0);
        chk("rstw.arready", 64'(arready), 64'd0);
        chk("rstw.awready", 64'(awready), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rstw.arready_before_edge", 64'(arready), 64'd0);
        @(negedge clock);
        chk("rstw.arready_after", 64'(arready), 64'd1);
        do_read("rstw.reread", 32'h0f000010, 4'hC, 8'd0, 3'd3, 1'b0, got);
        chk("rstw.reread_value", got, 64'h1122334455667788);

        // reset while a burst beat is being presented
        araddr = BASE; arid = 4'hB; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01; rready = 1'b0;
        arvalid = 1'b1;
        @(negedge clock);
        arvalid = 1'b0;
        cyc = 0;
        while (!rvalid && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        chk("rstd.rvalid_pre", 64'(rvalid), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstd.rvalid", 64'(rvalid), 64'd0);
        chk("rstd.rdata", rdata, 64'd0);
        chk("rstd.rid", 64'(rid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rstd.arready_after", 64'(arready), 64'd1);
        chk("rstd.rvalid_after", 64'(rvalid), 64'd0);

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = BASE + 32'($urandom_range(0, 31) * 8);
                if ($urandom_range(0, 7) == 0) a = a + 32'(SPAN);
                len = ($urandom_range(0, 5) == 0) ? 8'd1 : 8'd0;
                do_write("rnd_wr", a, {$urandom, $urandom}, 8'($urandom), 4'($urandom),
                         len, $urandom_range(0, 6) - 3, $urandom_range(0, 2));
            end else begin
                sz = 3'($urandom_range(0, 7));
                step = 1 << ((sz > 3'd3) ? 3 : int'(sz));
                len = 8'($urandom_range(0, 7));
                start = $urandom_range(0, 256 / step - 1 - int'(len));
                snap = 64'd0;
                do_read("rnd_rd", BASE + 32'(start * step), 4'($urandom), len, sz,
                        1'($urandom), snap);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
